// File: rtl/rsa_core.sv
// rsa_core: small RSA engine for 8-bit prime pairs.
// It derives n, e and d in three start-sequenced phases (key generation,
// inverse, cipher), then raises one 16-bit word to e (encryptor) or d
// (decryptor) modulo n using right-to-left square-and-multiply.
module rsa_core #(
    parameter int InstructionSelector = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Input,
    input  logic [7:0]  firstPrimeNumber,
    input  logic [7:0]  secondPrimeNumber,
    input  logic        start,
    input  logic        start1,
    input  logic        start2,
    output logic [7:0]  encryptionKey,
    output logic [15:0] n,
    output logic [15:0] decryptionKey,
    output logic [15:0] Output,
    output logic        fin1,
    output logic        finish
);

    typedef enum logic [2:0] {
        IDLE, KEYGEN, KEYDONE, INV, INVDONE, EXP, DONE
    } state_t;

    state_t             state_q;
    logic               startPrev_q, start1Prev_q, start2Prev_q;
    logic [15:0]        n_q, phi_q;
    logic [7:0]         eKey_q, eCand_q;
    logic [15:0]        gcdA_q, gcdB_q;
    logic [15:0]        r0_q, r1_q;
    logic signed [17:0] t0_q, t1_q;
    logic [15:0]        dKey_q;
    logic [15:0]        base_q, res_q, exp_q;
    logic               sqPhase_q;
    logic [15:0]        out_q;
    logic               fin1_q, finish_q;

    logic               startRise, start1Rise, start2Rise;
    logic [15:0]        pMinus_d, qMinus_d, phiIn_d, nIn_d;
    logic [15:0]        gcdRem_d, quot_d, rem_d;
    logic signed [17:0] quotS_d, tNext_d;
    logic [15:0]        dFinal_d, expKey_d, inRed_d, mulA_d, modProd_d;
    logic [31:0]        prod_d;
    logic [7:0]         eCandNext_d;

    // Each start input only counts on its rising edge, so a held level is a single request.
    always_comb begin
        startRise  = start  & ~startPrev_q;
        start1Rise = start1 & ~start1Prev_q;
        start2Rise = start2 & ~start2Prev_q;
    end

    // Datapath arithmetic: key derivation, one Euclid step, one extended-Euclid step, one modular multiply.
    always_comb begin
        pMinus_d    = {8'b0, firstPrimeNumber} - 16'd1;
        qMinus_d    = {8'b0, secondPrimeNumber} - 16'd1;
        phiIn_d     = pMinus_d * qMinus_d;
        nIn_d       = {8'b0, firstPrimeNumber} * {8'b0, secondPrimeNumber};
        eCandNext_d = eCand_q + 8'd2;
        gcdRem_d    = (gcdB_q == 16'd0) ? 16'd0 : gcdA_q % gcdB_q;
        quot_d      = (r1_q == 16'd0) ? 16'd0 : r0_q / r1_q;
        rem_d       = (r1_q == 16'd0) ? 16'd0 : r0_q % r1_q;
        quotS_d     = signed'({2'b00, quot_d});
        tNext_d     = t0_q - quotS_d * t1_q;
        dFinal_d    = t0_q[15:0] + (t0_q[17] ? phi_q : 16'd0);
        expKey_d    = (InstructionSelector != 0) ? {8'b0, eKey_q} : dKey_q;
        inRed_d     = (n_q == 16'd0) ? 16'd0 : Input % n_q;
        mulA_d      = sqPhase_q ? base_q : res_q;
        prod_d      = {16'b0, mulA_d} * {16'b0, base_q};
        modProd_d   = (n_q == 16'd0) ? 16'd0 : 16'(prod_d % {16'b0, n_q});
    end

    // Main sequencer: accepts start requests in the resting states and runs each iterative phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            startPrev_q  <= 1'b0;
            start1Prev_q <= 1'b0;
            start2Prev_q <= 1'b0;
            n_q          <= 16'd0;
            phi_q        <= 16'd0;
            eKey_q       <= 8'd0;
            eCand_q      <= 8'd0;
            gcdA_q       <= 16'd0;
            gcdB_q       <= 16'd0;
            r0_q         <= 16'd0;
            r1_q         <= 16'd0;
            t0_q         <= 18'sd0;
            t1_q         <= 18'sd0;
            dKey_q       <= 16'd0;
            base_q       <= 16'd0;
            res_q        <= 16'd0;
            exp_q        <= 16'd0;
            sqPhase_q    <= 1'b0;
            out_q        <= 16'd0;
            fin1_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            startPrev_q  <= start;
            start1Prev_q <= start1;
            start2Prev_q <= start2;
            case (state_q)
                IDLE, KEYDONE, INVDONE, DONE: begin
                    if (startRise) begin
                        n_q      <= nIn_d;
                        fin1_q   <= 1'b0;
                        finish_q <= 1'b0;
                        if (firstPrimeNumber < 8'd2 || secondPrimeNumber < 8'd2) begin
                            eKey_q  <= 8'd0;
                            phi_q   <= 16'd0;
                            state_q <= KEYDONE;
                        end else begin
                            phi_q   <= phiIn_d;
                            eCand_q <= 8'd3;
                            gcdA_q  <= phiIn_d;
                            gcdB_q  <= 16'd3;
                            state_q <= KEYGEN;
                        end
                    end else if (start1Rise && state_q != IDLE) begin
                        if (eKey_q == 8'd0) begin
                            dKey_q  <= 16'd0;
                            fin1_q  <= 1'b1;
                            state_q <= INVDONE;
                        end else begin
                            r0_q    <= phi_q;
                            r1_q    <= {8'b0, eKey_q};
                            t0_q    <= 18'sd0;
                            t1_q    <= 18'sd1;
                            state_q <= INV;
                        end
                    end else if (start2Rise && (state_q == INVDONE || state_q == DONE)) begin
                        finish_q  <= 1'b0;
                        base_q    <= inRed_d;
                        res_q     <= (n_q <= 16'd1) ? 16'd0 : 16'd1;
                        exp_q     <= expKey_d;
                        sqPhase_q <= 1'b0;
                        state_q   <= EXP;
                    end
                end
                KEYGEN: begin
                    if (gcdB_q != 16'd0) begin
                        gcdA_q <= gcdB_q;
                        gcdB_q <= gcdRem_d;
                    end else if (gcdA_q == 16'd1) begin
                        eKey_q  <= eCand_q;
                        state_q <= KEYDONE;
                    end else if (eCand_q == 8'd255) begin
                        eKey_q  <= 8'd0;
                        state_q <= KEYDONE;
                    end else begin
                        eCand_q <= eCandNext_d;
                        gcdA_q  <= phi_q;
                        gcdB_q  <= {8'b0, eCandNext_d};
                    end
                end
                INV: begin
                    if (r1_q == 16'd0) begin
                        dKey_q  <= dFinal_d;
                        fin1_q  <= 1'b1;
                        state_q <= INVDONE;
                    end else begin
                        r0_q <= r1_q;
                        r1_q <= rem_d;
                        t0_q <= t1_q;
                        t1_q <= tNext_d;
                    end
                end
                EXP: begin
                    if (!sqPhase_q) begin
                        if (exp_q == 16'd0) begin
                            out_q    <= res_q;
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            if (exp_q[0]) begin
                                res_q <= modProd_d;
                            end
                            sqPhase_q <= 1'b1;
                        end
                    end else begin
                        base_q    <= modProd_d;
                        exp_q     <= exp_q >> 1;
                        sqPhase_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign encryptionKey = eKey_q;
    assign n             = n_q;
    assign decryptionKey = dKey_q;
    assign Output        = out_q;
    assign fin1          = fin1_q;
    assign finish        = finish_q;

endmodule

// File: tb/tb_rsa_core.sv
// Testbench for rsa_core: an encryptor and a decryptor share one stimulus
// stream; expected keys and results are queued by the stimulus side and
// compared by monitors whenever fin1 or finish rises.
module tb_rsa_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] dataIn;
    logic [7:0]  pIn, qIn;
    logic        start, start1, start2;
    logic [7:0]  encE, decE;
    logic [15:0] encN, decN, encD, decD, encOut, decOut;
    logic        encFin1, decFin1, encFinish, decFinish;

    rsa_core #(.InstructionSelector(1)) encDut (
        .clk(clk), .rst_n(rst_n), .Input(dataIn),
        .firstPrimeNumber(pIn), .secondPrimeNumber(qIn),
        .start(start), .start1(start1), .start2(start2),
        .encryptionKey(encE), .n(encN), .decryptionKey(encD),
        .Output(encOut), .fin1(encFin1), .finish(encFinish)
    );

    rsa_core #(.InstructionSelector(0)) decDut (
        .clk(clk), .rst_n(rst_n), .Input(dataIn),
        .firstPrimeNumber(pIn), .secondPrimeNumber(qIn),
        .start(start), .start1(start1), .start2(start2),
        .encryptionKey(decE), .n(decN), .decryptionKey(decD),
        .Output(decOut), .fin1(decFin1), .finish(decFinish)
    );

    typedef struct {
        int e;
        int n;
        int d;
    } keyT;

    int  total = 0;
    int  bad   = 0;
    keyT keyQ[$];
    int  encQ[$];
    int  decQ[$];
    keyT popKey;
    int  popVal;
    int  curE, curN, curD;
    logic encFin1Prev = 1'b0, encFinishPrev = 1'b0, decFinishPrev = 1'b0;

    int primes[] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61,
                     67, 71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137,
                     139, 149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211,
                     223, 227, 229, 233, 239, 241, 251};

    // Reference model: plain number theory, no notion of cycles.
    function automatic int modelGcd(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int modelE(int p, int q);
        int phi;
        if (p < 2 || q < 2) return 0;
        phi = (p - 1) * (q - 1);
        for (int e = 3; e <= 255; e += 2)
            if (modelGcd(e, phi) == 1) return e;
        return 0;
    endfunction

    function automatic int modelD(int e, int phi);
        if (e == 0) return 0;
        for (int k = 1; k < phi; k++)
            if ((e * k) % phi == 1) return k;
        return 0;
    endfunction

    function automatic int modelPow(int base, int k, int m);
        longint r, b;
        if (m == 0) return 0;
        r = 1 % m;
        b = base % m;
        for (int i = 0; i < k; i++) r = (r * b) % m;
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // which: 0 = start, 1 = start1, 2 = start2; one-cycle pulse
    task automatic applyStimulus(input int which);
        @(posedge clk); #2;
        if (which == 0) start = 1'b1;
        else if (which == 1) start1 = 1'b1;
        else start2 = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic waitFin1();
        int cnt = 0;
        while (!(encFin1 && decFin1) && cnt < 45) begin
            @(negedge clk);
            cnt++;
        end
        if (!(encFin1 && decFin1)) begin
            total++; bad++;
            $display("[TB] FAIL fin1Timeout: got fin1 %0b/%0b expected 1/1", encFin1, decFin1);
        end
    endtask

    task automatic waitFinish();
        int cnt = 0;
        while (!(encFinish && decFinish) && cnt < 45) begin
            @(negedge clk);
            cnt++;
        end
        if (!(encFinish && decFinish)) begin
            total++; bad++;
            $display("[TB] FAIL finishTimeout: got finish %0b/%0b expected 1/1", encFinish, decFinish);
        end
    endtask

    task automatic keygenOnly(input int p, input int q);
        pIn = 8'(p); qIn = 8'(q);
        applyStimulus(0);
        repeat (205) @(posedge clk);
        curN = p * q;
        curE = modelE(p, q);
        curD = modelD(curE, (p - 1) * (q - 1));
    endtask

    task automatic runInverse();
        keyT k;
        k.e = curE; k.n = curN; k.d = curD;
        keyQ.push_back(k);
        applyStimulus(1);
        waitFin1();
    endtask

    task automatic runCipher(input int x);
        dataIn = 16'(x);
        encQ.push_back(modelPow(x, curE, curN));
        decQ.push_back(modelPow(x, curD, curN));
        applyStimulus(2);
        waitFinish();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_encE"}, 32'(encE), 0);
        checkOutput({tag, "_encN"}, 32'(encN), 0);
        checkOutput({tag, "_encD"}, 32'(encD), 0);
        checkOutput({tag, "_encOut"}, 32'(encOut), 0);
        checkOutput({tag, "_encFlags"}, {30'b0, encFin1, encFinish}, 0);
        checkOutput({tag, "_decE"}, 32'(decE), 0);
        checkOutput({tag, "_decN"}, 32'(decN), 0);
        checkOutput({tag, "_decD"}, 32'(decD), 0);
        checkOutput({tag, "_decOut"}, 32'(decOut), 0);
        checkOutput({tag, "_decFlags"}, {30'b0, decFin1, decFinish}, 0);
    endtask

    // Monitor: on each rising fin1/finish pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (encFin1 && !encFin1Prev) begin
            if (keyQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpectedFin1: got fin1 1 expected no event");
            end else begin
                popKey = keyQ.pop_front();
                checkOutput("keyEncE", 32'(encE), popKey.e);
                checkOutput("keyEncN", 32'(encN), popKey.n);
                checkOutput("keyEncD", 32'(encD), popKey.d);
                checkOutput("keyDecE", 32'(decE), popKey.e);
                checkOutput("keyDecN", 32'(decN), popKey.n);
                checkOutput("keyDecD", 32'(decD), popKey.d);
                checkOutput("keyDecFin1", 32'(decFin1), 1);
            end
        end
        if (encFinish && !encFinishPrev) begin
            if (encQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpectedEncFinish: got finish 1 expected no event");
            end else begin
                popVal = encQ.pop_front();
                checkOutput("encOutput", 32'(encOut), popVal);
            end
        end
        if (decFinish && !decFinishPrev) begin
            if (decQ.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpectedDecFinish: got finish 1 expected no event");
            end else begin
                popVal = decQ.pop_front();
                checkOutput("decOutput", 32'(decOut), popVal);
            end
        end
        encFin1Prev   = encFin1;
        encFinishPrev = encFinish;
        decFinishPrev = decFinish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end expected finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        rst_n = 1'b0; dataIn = 16'd0; pIn = 8'd0; qIn = 8'd0;
        start = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 67 x 53, with a premature start2 that must be ignored
        keygenOnly(67, 53);
        checkOutput("n3551", 32'(encN), 3551);
        checkOutput("e5", 32'(encE), 5);
        dataIn = 16'd1256;
        applyStimulus(2);
        repeat (50) @(negedge clk);
        checkOutput("earlyStart2Enc", 32'(encFinish), 0);
        checkOutput("earlyStart2Dec", 32'(decFinish), 0);
        runInverse();
        checkOutput("d1373", 32'(decD), 1373);
        runCipher(1256);
        checkOutput("dec1256", 32'(decOut), 11);
        runCipher(11);
        checkOutput("enc11", 32'(encOut), 1256);

        // start again from DONE clears both flags
        pIn = 8'd5; qIn = 8'd11;
        applyStimulus(0);
        @(negedge clk);
        checkOutput("restartFin1", {30'b0, encFin1, decFin1}, 0);
        checkOutput("restartFinish", {30'b0, encFinish, decFinish}, 0);
        repeat (205) @(posedge clk);
        curN = 55; curE = modelE(5, 11); curD = modelD(curE, 40);
        runInverse();
        checkOutput("e3", 32'(encE), 3);
        checkOutput("d27", 32'(decD), 27);
        runCipher(2);
        checkOutput("enc2", 32'(encOut), 8);
        runCipher(8);
        checkOutput("dec8", 32'(decOut), 2);
        runCipher(57);
        checkOutput("enc57", 32'(encOut), 8);

        // reset in the middle of an exponentiation
        dataIn = 16'd100;
        applyStimulus(2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("midReset");
        applyStimulus(2);
        repeat (50) @(negedge clk);
        checkOutput("postResetStart2", {30'b0, encFinish, decFinish}, 0);
        keygenOnly(5, 11);
        runInverse();
        runCipher(30);

        // randomized prime pairs and words
        for (int it = 0; it < 8; it++) begin
            int p, q;
            p = primes[$urandom_range(0, primes.size() - 1)];
            q = primes[$urandom_range(0, primes.size() - 1)];
            keygenOnly(p, q);
            runInverse();
            runCipher(int'($urandom_range(0, 65535)));
            runCipher(int'($urandom_range(0, curN > 0 ? curN - 1 : 0)));
        end

        repeat (5) @(negedge clk);
        checkOutput("keyQEmpty", 32'(keyQ.size()), 0);
        checkOutput("encQEmpty", 32'(encQ.size()), 0);
        checkOutput("decQEmpty", 32'(decQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_core.md
# rsa_core

RSA engine for 8-bit prime pairs. It derives the modulus, public exponent and private exponent, then performs one modular exponentiation on a 16-bit word. Parameter `InstructionSelector` builds it as an encryptor (uses e) or a decryptor (uses d). Three separate start pulses sequence key generation, inverse computation and the cipher operation.

## Interface
- `InstructionSelector`, default 1: 1 = encrypt (Output = Input^e mod n); 0 = decrypt (Output = Input^d mod n).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `Input` in 16: message or ciphertext word.
- `firstPrimeNumber` in 8: prime p.
- `secondPrimeNumber` in 8: prime q.
- `start` in 1: begin key generation.
- `start1` in 1: begin private-exponent computation.
- `start2` in 1: begin modular exponentiation.
- `encryptionKey` out 8: public exponent e.
- `n` out 16: modulus p·q.
- `decryptionKey` out 16: private exponent d.
- `Output` out 16: result word.
- `fin1` out 1: e and d valid.
- `finish` out 1: Output valid.

## Operation
- The FSM has these states: IDLE, KEYGEN, KEYDONE, INV, INVDONE, EXP, DONE.
- All start inputs are sampled on clock edges. A start input is accepted only when the FSM can take it. A start seen while busy is ignored.
- **start** is accepted in any non-busy state (IDLE, KEYDONE, INVDONE, DONE):
  - Latch p and q.
  - n = p·q, computed in 16 bits.
  - phi = (p−1)(q−1).
  - e = the smallest odd value ≥ 3 with gcd(e, phi) = 1. The search uses iterative Euclid, one remainder step per cycle.
  - Clear fin1 and finish, then go to KEYDONE.
  - If p < 2 or q < 2, or no e ≤ 255 is found, set e = 0 and go to KEYDONE.
- **start1** is accepted in KEYDONE or later:
  - d = e⁻¹ mod phi, computed by extended Euclid with one iteration per cycle.
  - d is in the range 1..phi−1.
  - Set fin1 and go to INVDONE.
  - If e = 0, d = 0 and fin1 is still set.
- **start2** is accepted in INVDONE or DONE:
  - Latch Input and reduce it mod n.
  - Compute Input^k mod n, where k = e or d as set by `InstructionSelector`.
  - Use right-to-left square-and-multiply with one modular multiply per cycle. Products are 32 bits, reduced mod n.
  - Clear finish at acceptance. Set finish and go to DONE when the result is ready.
  - If n = 0, Output = 0.
- start1 in IDLE and start2 before INVDONE are ignored.
- fin1 and finish are levels, not pulses. Each holds until a new start (both clear) or a new start2 (finish clears).
- The key outputs (e, n, d) hold their values after the corresponding phase completes.

## Timing
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts the operation immediately.
- start to KEYDONE: at most 200 cycles for any p, q ≤ 255. (e ≤ 17 always, since 3·5·7·11·13·17 exceeds any phi.)
- start1 to fin1: at most 40 cycles.
- start2 to finish: at most 40 cycles (16 exponent bits, up to 2 operations per bit).
- Outputs change only on clock edges. n and encryptionKey are valid when the FSM reaches KEYDONE.
- A start input held high for several cycles is treated as a single request. A new request needs a fresh low-to-high edge, so each start input is edge-detected internally.
- If more than one start input is asserted in the same cycle: start has priority, then start1, then start2.

## Test plan
- Decryptor instance, p=67, q=53, start → n=3551, e=5. Then start1 → d=1373, fin1=1. Then Input=1256, start2 → Output=11, finish=1.
- Encryptor instance, p=67, q=53, Input=11, full sequence → Output=1256. This matches the decrypt case as a round trip.
- p=5, q=11 → n=55, e=3, d=27. Encrypt 2 → 8. Decrypt 8 → 2.
- Input ≥ n (p=5, q=11, Input=57, encrypt) → Output=8, since 57 reduces to 2 first.
- Ordering rules:
  - start2 issued before start1 is ignored; finish stays 0.
  - start re-issued in DONE clears fin1 and finish, then regenerates the keys.
- Reset mid-exponentiation: drop rst_n for one cycle → all outputs 0, FSM in IDLE. start2 is then ignored until start and start1 are re-run.
